spi_frame_rx: RTL and testbench
===============================

Name: spi_frame_rx

Overview:
- SPI slave receiver: the far end of the measurement link driven by the SPI master in the measurement top level.
- Oversamples spi_sclk, spi_cs and spi_mosi in the sys_clk domain and captures 8 bytes MSB-first per chip-select frame.
- Rebuilds the 64-bit measurement word and splits it into high_times, all_times and fx.
- Used in the receiving FPGA and as the loopback checker for the sender.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on spi_sclk, spi_cs and spi_mosi; legal range 2..4.
- TIMEOUT_CYCLES, 1000000, sys_clk cycles with spi_cs low and no spi_sclk rising edge before the frame is aborted.

Ports:
- sys_clk  input  1  system clock, 100 MHz; spi_sclk must be no faster than sys_clk/8.
- rst  input  1  asynchronous, active-high reset.
- spi_sclk  input  1  SPI clock from the master; mode 0 (CPOL=0, CPHA=0).
- spi_cs  input  1  chip select, active low.
- spi_mosi  input  1  serial data from the master.
- spi_miso  output  1  serial data to the master.
- byte_rec  output  8  last complete received byte.
- byte_done  output  1  one-cycle pulse when byte_rec updates.
- data64  output  64  last good frame; first received byte is data64[63:56].
- high_times  output  16  data64[63:48].
- all_times  output  16  data64[47:32].
- fx  output  32  data64[31:0].
- frame_valid  output  1  one-cycle pulse; data64 and the field outputs updated in the same cycle.
- frame_err  output  1  one-cycle pulse when a frame is malformed or aborted.

Behaviour:
- Reset: async on rst high.
  - All outputs are 0; spi_miso is 0.
  - Synchronisers are preset to idle (sclk=0, cs=1, mosi=0).
  - State is IDLE; counters are 0.
- Edge detection: done on the last synchroniser stage plus one delay flop.
  - sclk_rise, cs_fall and cs_rise are single-cycle strobes.
- FSM states: IDLE, RECV, DONE, ERR.
- IDLE:
  - On cs_fall: go to RECV; clear bit_cnt (3 bits), byte_cnt (4 bits), shift register and timeout counter.
- RECV:
  - On sclk_rise: shift the synchronised mosi into the LSB; bit_cnt increments.
  - When bit_cnt wraps 7->0:
    - byte_rec <= shifted byte; byte_done pulses the next cycle.
    - The byte is appended to a 64-bit frame shift register; byte_cnt increments, saturating at 9.
  - Timeout counter clears on every sclk_rise and increments otherwise. Reaching TIMEOUT_CYCLES goes to ERR.
  - On cs_rise: DONE if byte_cnt==8 and bit_cnt==0; otherwise ERR. Covers short frames, long frames (byte_cnt 9) and partial bytes.
  - If sclk_rise and cs_rise occur in the same cycle, the bit is shifted first, then the cs_rise check is evaluated on the updated counters.
- DONE (one cycle):
  - Load data64 and the field outputs from the frame register; pulse frame_valid; go to IDLE.
  - Latency: frame_valid is high 1 cycle after the cs_rise strobe.
- ERR (one cycle):
  - Pulse frame_err; data64 and the fields hold their previous values; go to IDLE.
  - After a timeout abort, wait in IDLE for the next cs_fall. A cs_rise arriving later is ignored.
- cs_fall while in RECV (glitch / re-select): treated as cs_rise with an error, then a fresh frame. Implemented as ERR, then IDLE, re-arming on the next cs_fall.
- spi_miso is driven 0 whenever spi_cs is high.

Optional Feature:
- Macro: SPI_MISO_ECHO_EN.
- Defined:
  - spi_miso returns the previous received byte, MSB first, during the next byte slot of the same frame.
  - Bits are updated on each synchronised sclk falling edge; bit 7 is presented at cs_fall.
  - During the first byte the echo value is 8'h00.
  - The master can verify the link by comparing its send and receive bytes with a one-byte lag.
- Not defined: spi_miso is constant 0; no echo register is built.

Test Plan:
- Reset asserted mid-frame after 3 bytes, then released; new 8-byte frame 0x0012_3456_0001_86A0 -> all outputs 0 during reset, no pulses; frame_valid once; high_times=0x0012, all_times=0x3456, fx=0x000186A0.
- Two back-to-back frames 0x0102030405060708 and 0xFFEEDDCCBBAA9988 at sclk = sys_clk/100 -> two frame_valid pulses, each 1 cycle after the cs_rise strobe; 8 byte_done pulses per frame with byte_rec values in order.
- Frame of 7 bytes, frame of 9 bytes, and frame of 8 bytes plus 3 extra bits -> frame_err once each; data64 keeps the last good value; no frame_valid.
- cs held low, 2 bytes sent, then sclk stopped for TIMEOUT_CYCLES (bench overrides to 500) -> frame_err at the 500th idle cycle. The following cs_rise produces no pulse; the next good frame is accepted.
- SPI_MISO_ECHO_EN defined, frame bytes 0xA5,0x3C,... -> master samples 0x00 in slot 0 and 0xA5 in slot 1; with the macro undefined, miso stays 0 throughout.

Source files
------------

// File: rtl/spi_frame_rx_if.sv
// SPI link pins between the measurement master and the frame receiver.
interface spi_frame_rx_if;
    logic spi_sclk;
    logic spi_cs;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_sclk, output spi_cs, output spi_mosi, input spi_miso);
    modport slave  (input spi_sclk, input spi_cs, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave that receives 8-byte measurement frames and splits them into fields.
// Optional SPI_MISO_ECHO_EN: echo the previous received byte on spi_miso with a one-byte lag.
module spi_frame_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic           sys_clk,
    input  logic           rst,
    spi_frame_rx_if.slave  spi,
    output logic [7:0]     byte_rec,
    output logic           byte_done,
    output logic [63:0]    data64,
    output logic [15:0]    high_times,
    output logic [15:0]    all_times,
    output logic [31:0]    fx,
    output logic           frame_valid,
    output logic           frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, DONE, ERR} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, cs_fall, cs_rise;

    state_t      state, state_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [3:0]  byte_cnt, byte_cnt_n;
    logic [7:0]  shift_q, shift_n;
    logic [63:0] frame_q, frame_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [7:0]  byte_rec_n;
    logic        byte_done_n;
    logic [63:0] data64_n;

    // Synchronisers start in the idle line state so reset release never fakes an edge.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shift_q   <= '0;
            frame_q   <= '0;
            tmo       <= '0;
            byte_rec  <= '0;
            byte_done <= 1'b0;
            data64    <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            byte_cnt  <= byte_cnt_n;
            shift_q   <= shift_n;
            frame_q   <= frame_n;
            tmo       <= tmo_n;
            byte_rec  <= byte_rec_n;
            byte_done <= byte_done_n;
            data64    <= data64_n;
        end
    end

    // The end-of-frame check uses the counters after any same-cycle shift.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        byte_cnt_n  = byte_cnt;
        shift_n     = shift_q;
        frame_n     = frame_q;
        tmo_n       = tmo;
        byte_rec_n  = byte_rec;
        byte_done_n = 1'b0;
        data64_n    = data64;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n    = RECV;
                    bit_cnt_n  = '0;
                    byte_cnt_n = '0;
                    shift_n    = '0;
                    frame_n    = '0;
                    tmo_n      = '0;
                end
            end
            RECV: begin
                if (sclk_rise) begin
                    shift_n   = {shift_q[6:0], mosi_s};
                    bit_cnt_n = bit_cnt + 3'd1;
                    tmo_n     = '0;
                    if (bit_cnt == 3'd7) begin
                        byte_rec_n  = shift_n;
                        byte_done_n = 1'b1;
                        frame_n     = {frame_q[55:0], shift_n};
                        if (byte_cnt != 4'd9) begin
                            byte_cnt_n = byte_cnt + 4'd1;
                        end
                    end
                end else begin
                    tmo_n = tmo + TW'(1);
                end
                if (cs_fall) begin
                    state_n = ERR;
                end else if (cs_rise) begin
                    if (byte_cnt_n == 4'd8 && bit_cnt_n == 3'd0) begin
                        state_n  = DONE;
                        data64_n = frame_n;
                    end else begin
                        state_n = ERR;
                    end
                end else if (!sclk_rise && tmo_n == TW'(TIMEOUT_CYCLES)) begin
                    state_n = ERR;
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign frame_valid = (state == DONE);
    assign frame_err   = (state == ERR);
    assign high_times  = data64[63:48];
    assign all_times   = data64[47:32];
    assign fx          = data64[31:0];

`ifdef SPI_MISO_ECHO_EN
    logic       sclk_fall;
    logic [7:0] echo_sh;

    assign sclk_fall = ~sclk_s & sclk_d;

    // At a byte boundary the falling edge loads the byte just completed; otherwise shift out.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            echo_sh <= '0;
        end else if (state == IDLE && cs_fall) begin
            echo_sh <= '0;
        end else if (state == RECV && sclk_fall) begin
            if (bit_cnt == 3'd0 && byte_cnt != 4'd0) begin
                echo_sh <= byte_rec;
            end else begin
                echo_sh <= {echo_sh[6:0], 1'b0};
            end
        end
    end

    assign spi.spi_miso = ~spi.spi_cs & echo_sh[7];
`else
    assign spi.spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomised self-checking bench for spi_frame_rx against a byte/frame-level model.
module tb_spi_frame_rx;
    localparam int SYNC = 2;
    localparam int TMO  = 500;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_rec;
    logic        byte_done;
    logic [63:0] data64;
    logic [15:0] high_times;
    logic [15:0] all_times;
    logic [31:0] fx;
    logic        frame_valid;
    logic        frame_err;

    spi_frame_rx_if spi_bus();

    spi_frame_rx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .spi         (spi_bus.slave),
        .byte_rec    (byte_rec),
        .byte_done   (byte_done),
        .data64      (data64),
        .high_times  (high_times),
        .all_times   (all_times),
        .fx          (fx),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  miso_q[$];
    logic [7:0]  miso_acc;
    int          miso_bitn;
    int          valid_n = 0, err_n = 0, valid_cyc = 0, err_cyc = 0;
    int          v0, e0;
    int          cs_rise_cyc, last_rise_cyc;
    logic [63:0] good_word = 64'h0;

    // Observer: records byte strobes and frame pulses away from the active edge.
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (byte_done) rx_q.push_back(byte_rec);
            if (frame_valid) begin
                valid_n++;
                valid_cyc = cyc;
            end
            if (frame_err) begin
                err_n++;
                err_cyc = cyc;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic driveBit(input logic b, input int half);
        spi_bus.spi_mosi = b;
        repeat (half) @(negedge sys_clk);
        miso_acc = {miso_acc[6:0], spi_bus.spi_miso};
        miso_bitn++;
        if (miso_bitn % 8 == 0) miso_q.push_back(miso_acc);
        spi_bus.spi_sclk = 1'b1;
        last_rise_cyc = cyc;
        repeat (half) @(negedge sys_clk);
        spi_bus.spi_sclk = 1'b0;
    endtask

    task automatic sendBits(input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            logic [7:0] b;
            b = tx_q[i / 8];
            driveBit(b[7 - (i % 8)], half);
        end
    endtask

    task automatic csLow(input int half);
        rx_q.delete();
        miso_q.delete();
        miso_acc = 8'h00;
        miso_bitn = 0;
        v0 = valid_n;
        e0 = err_n;
        spi_bus.spi_cs = 1'b0;
        repeat (half) @(negedge sys_clk);
    endtask

    task automatic csHigh(input int half);
        repeat (half) @(negedge sys_clk);
        spi_bus.spi_cs = 1'b1;
        cs_rise_cyc = cyc;
        repeat (12) @(negedge sys_clk);
    endtask

    task automatic applyStimulus(input int nbits, input int half);
        csLow(half);
        sendBits(nbits, half);
        csHigh(half);
    endtask

    task automatic setFrame(input logic [63:0] w);
        tx_q.delete();
        for (int k = 0; k < 8; k++) tx_q.push_back(w[63 - 8 * k -: 8]);
    endtask

    task automatic setRandom(input int nbytes);
        tx_q.delete();
        for (int k = 0; k < nbytes; k++) tx_q.push_back(8'($urandom));
    endtask

    // Expected results come from the transmitted bytes: whole bytes are reported,
    // only an exact 64-bit frame is accepted, and bad frames keep the old word.
    task automatic checkFrame(input string name, input int nbits);
        int nb;
        logic good;
        logic [63:0] w;
        logic [63:0] got;
        logic [7:0] exp_miso;
        nb = nbits / 8;
        good = (nbits == 64);
        w = 64'h0;
        checkOutput({name, "_byte_count"}, 64'(rx_q.size()), 64'(nb));
        for (int k = 0; k < nb; k++) begin
            got = (k < rx_q.size()) ? 64'(rx_q[k]) : 64'hx;
            checkOutput($sformatf("%s_byte%0d", name, k), got, 64'(tx_q[k]));
        end
        if (good) begin
            for (int k = 0; k < 8; k++) w = {w[55:0], tx_q[k]};
            good_word = w;
        end
        checkOutput({name, "_valid_pulses"}, 64'(valid_n - v0), good ? 64'd1 : 64'd0);
        checkOutput({name, "_err_pulses"}, 64'(err_n - e0), good ? 64'd0 : 64'd1);
        if (good) checkOutput({name, "_valid_latency"}, 64'(valid_cyc - cs_rise_cyc), 64'(SYNC + 1));
        checkOutput({name, "_data64"}, data64, good_word);
        checkOutput({name, "_high_times"}, 64'(high_times), 64'(good_word[63:48]));
        checkOutput({name, "_all_times"}, 64'(all_times), 64'(good_word[47:32]));
        checkOutput({name, "_fx"}, 64'(fx), 64'(good_word[31:0]));
        for (int k = 0; k < miso_q.size(); k++) begin
`ifdef SPI_MISO_ECHO_EN
            exp_miso = (k == 0) ? 8'h00 : tx_q[k - 1];
`else
            exp_miso = 8'h00;
`endif
            checkOutput($sformatf("%s_miso_slot%0d", name, k), 64'(miso_q[k]), 64'(exp_miso));
        end
    endtask

    initial begin
        int nbits, half, waited;
        spi_bus.spi_sclk = 1'b0;
        spi_bus.spi_cs   = 1'b1;
        spi_bus.spi_mosi = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge sys_clk);
        checkOutput("reset_data64", data64, 64'h0);
        checkOutput("reset_byte_rec", 64'(byte_rec), 64'h0);
        checkOutput("reset_strobes", 64'({byte_done, frame_valid, frame_err, spi_bus.spi_miso}), 64'h0);
        rst = 1'b0;
        repeat (5) @(negedge sys_clk);

        // Reset in the middle of a frame, after three bytes.
        tx_q = {8'h11, 8'h22, 8'h33};
        csLow(8);
        sendBits(24, 8);
        repeat (4) @(negedge sys_clk);
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        checkOutput("midrst_byte_rec", 64'(byte_rec), 64'h0);
        checkOutput("midrst_data64", data64, 64'h0);
        checkOutput("midrst_strobes", 64'({byte_done, frame_valid, frame_err, spi_bus.spi_miso}), 64'h0);
        spi_bus.spi_cs = 1'b1;
        repeat (4) @(negedge sys_clk);
        rst = 1'b0;
        repeat (20) @(negedge sys_clk);
        checkOutput("midrst_no_pulses", 64'((valid_n - v0) + (err_n - e0)), 64'h0);

        setFrame(64'h0012_3456_0001_86A0);
        applyStimulus(64, 8);
        checkFrame("post_reset", 64);

        setFrame(64'h0102030405060708);
        applyStimulus(64, 50);
        checkFrame("b2b_a", 64);
        setFrame(64'hFFEEDDCCBBAA9988);
        applyStimulus(64, 50);
        checkFrame("b2b_b", 64);

        setRandom(7);
        applyStimulus(56, 8);
        checkFrame("short7", 56);
        setRandom(9);
        applyStimulus(72, 8);
        checkFrame("long9", 72);
        setRandom(9);
        applyStimulus(67, 8);
        checkFrame("extra3", 67);

        tx_q = {8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h01, 8'h80, 8'h7E, 8'hE7};
        applyStimulus(64, 4);
        checkFrame("echo", 64);

        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 4))
                0:       nbits = 56;
                1:       nbits = 64 + $urandom_range(1, 8);
                default: nbits = 64;
            endcase
            half = $urandom_range(4, 12);
            setRandom(9);
            applyStimulus(nbits, half);
            checkFrame($sformatf("rand%0d", r), nbits);
        end

        // Two bytes, then the clock stops with chip select held low.
        setRandom(2);
        csLow(6);
        sendBits(16, 6);
        waited = 0;
        while (err_n == e0 && waited < TMO + 100) begin
            @(negedge sys_clk);
            waited++;
        end
        checkOutput("timeout_fired", 64'(err_n - e0), 64'd1);
        checkOutput("timeout_latency", 64'(err_cyc - last_rise_cyc), 64'(TMO + SYNC + 1));
        checkOutput("timeout_bytes", 64'(rx_q.size()), 64'd2);
        csHigh(6);
        repeat (20) @(negedge sys_clk);
        checkOutput("timeout_cs_rise_err", 64'(err_n - e0), 64'd1);
        checkOutput("timeout_cs_rise_valid", 64'(valid_n - v0), 64'd0);
        checkOutput("timeout_data64_hold", data64, good_word);

        setRandom(8);
        applyStimulus(64, 6);
        checkFrame("after_timeout", 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a wait ever hangs.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
